// File: rtl/slog_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slog_pkg
//  Description : Shared types and constants for the log sprite line fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package slog_pkg;

    localparam int c_spr_w_default = 48;
    localparam int c_spr_h_default = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } slog_state_e;

    typedef logic [7:0] pal_idx_t;

    localparam pal_idx_t c_pal_transparent = 8'd0;

endpackage
`default_nettype wire

// File: rtl/slog_line_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : slog_line_fetcher_if
//  Description : Sprite ROM read bus (column/row address out, palette data in).
//  Revision    : 1.0 - initial release
// ============================================================================
interface slog_line_fetcher_if;
    import slog_pkg::*;

    logic [5:0] rom_DX;
    logic [5:0] rom_DY;
    pal_idx_t   rom_data;

    modport master (output rom_DX, output rom_DY, input  rom_data);
    modport slave  (input  rom_DX, input  rom_DY, output rom_data);

endinterface
`default_nettype wire

// File: rtl/slog_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : slog_line_buf
//  Description : One-row sprite buffer, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module slog_line_buf
    import slog_pkg::*;
#(
    parameter int DEPTH = c_spr_w_default
) (
    input  wire logic       Clk,
    input  wire logic       we,
    input  wire logic [5:0] waddr,
    input  wire pal_idx_t   wdata,
    input  wire logic [5:0] raddr,
    output pal_idx_t        rdata
);

    pal_idx_t r_mem [DEPTH];

    // Capture one ROM return per cycle
    always_ff @(posedge Clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Out-of-range reads return transparent rather than X
    assign rdata = (raddr < 6'(DEPTH)) ? r_mem[raddr] : c_pal_transparent;

endmodule
`default_nettype wire

// File: rtl/slog_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : slog_line_fetcher
//  Description : Fetches the next scanline's sprite row during hblank into a
//                line buffer and serves (optionally mirrored) pixels on display.
//  Revision    : 1.0 - initial release
// ============================================================================
module slog_line_fetcher
    import slog_pkg::*;
#(
    parameter int SPR_W   = c_spr_w_default,
    parameter int SPR_H   = c_spr_h_default,
    parameter int V_TOTAL = 525,
    parameter int ROM_LAT = 1
) (
    input  wire logic               Clk,
    input  wire logic               Reset,
    input  wire logic [9:0]         DrawX,
    input  wire logic [9:0]         DrawY,
    input  wire logic               line_start,
    input  wire logic [9:0]         LogX,
    input  wire logic [9:0]         LogY,
    input  wire logic               dir,
    slog_line_fetcher_if.master     rom,
    output pal_idx_t                pixel_idx,
    output logic                    pixel_valid,
    output logic                    busy
);

    localparam logic [1:0] c_idle  = ST_IDLE;
    localparam logic [1:0] c_fetch = ST_FETCH;
    localparam logic [1:0] c_drain = ST_DRAIN;

    logic [1:0]         r_state;
    logic [5:0]         r_cnt;
    logic [5:0]         r_row;
    logic [5:0]         r_dx_hold;
    logic [5:0]         r_dy_hold;
    logic [9:0]         r_logx;
    logic               r_dir;
    logic               r_row_hit;
    logic               r_row_hit_next;
    logic [ROM_LAT-1:0] r_pv;
    logic [5:0]         r_pa [ROM_LAT];
    pal_idx_t           r_pixel_idx;
    logic               r_pixel_valid;

    logic [9:0]         w_ny_inc;
    logic [9:0]         w_ny;
    logic [9:0]         w_r;
    logic               w_start_hit;
    logic               w_issue;
    logic               w_last_issue;
    logic               w_we;
    logic [5:0]         w_waddr;
    logic               w_last_write;
    logic [9:0]         w_c;
    logic               w_hit;
    logic [5:0]         w_col;
    pal_idx_t           w_rdata;

    // Row of the sprite needed on the next scanline (wraps at frame end)
    assign w_ny_inc    = DrawY + 10'd1;
    assign w_ny        = (w_ny_inc == 10'(V_TOTAL)) ? 10'd0 : w_ny_inc;
    assign w_r         = w_ny - LogY;
    assign w_start_hit = (w_r < 10'(SPR_H));

    assign w_issue      = (r_state == c_fetch);
    assign w_last_issue = w_issue && (r_cnt == 6'(SPR_W - 1));

    // A write landing on an abort or reset edge belongs to a dead fetch
    assign w_we         = r_pv[ROM_LAT-1] && !line_start && !Reset;
    assign w_waddr      = r_pa[ROM_LAT-1];
    assign w_last_write = w_we && (w_waddr == 6'(SPR_W - 1));

    // Address is live from the counter while fetching, held otherwise
    assign rom.rom_DX = w_issue ? r_cnt : r_dx_hold;
    assign rom.rom_DY = w_issue ? r_row : r_dy_hold;

    // Delay issued addresses by the ROM latency to pair them with returns
    generate
        for (genvar i = 0; i < ROM_LAT; i++) begin : g_pipe
            if (i == 0) begin : g_first
                // First stage samples the issue strobe and column
                always_ff @(posedge Clk) begin
                    if (Reset || line_start) begin
                        r_pv[0] <= 1'b0;
                    end else begin
                        r_pv[0] <= w_issue;
                    end
                    r_pa[0] <= r_cnt;
                end
            end else begin : g_rest
                // Later stages shift the strobe and column along
                always_ff @(posedge Clk) begin
                    if (Reset || line_start) begin
                        r_pv[i] <= 1'b0;
                    end else begin
                        r_pv[i] <= r_pv[i-1];
                    end
                    r_pa[i] <= r_pa[i-1];
                end
            end
        end
    endgenerate

    // Fetch sequencer: start/abort on line_start, issue SPR_W reads, drain
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= c_idle;
            r_cnt          <= 6'd0;
            r_row          <= 6'd0;
            r_dx_hold      <= 6'd0;
            r_dy_hold      <= 6'd0;
            r_logx         <= 10'd0;
            r_dir          <= 1'b0;
            r_row_hit      <= 1'b0;
            r_row_hit_next <= 1'b0;
        end else begin
            if (w_issue) begin
                r_dx_hold <= r_cnt;
                r_dy_hold <= r_row;
            end
            if (line_start) begin
                if (w_start_hit) begin
                    r_row          <= w_r[5:0];
                    r_logx         <= LogX;
                    r_dir          <= dir;
                    r_cnt          <= 6'd0;
                    r_row_hit_next <= 1'b1;
                    r_state        <= c_fetch;
                end else begin
                    r_row_hit_next <= 1'b0;
                    r_row_hit      <= 1'b0;
                    r_state        <= c_idle;
                end
            end else begin
                if (w_last_write) begin
                    r_row_hit <= r_row_hit_next;
                end
                case (r_state)
                    c_fetch: begin
                        r_cnt <= r_cnt + 6'd1;
                        if (w_last_issue) begin
                            r_state <= c_drain;
                        end
                    end
                    c_drain: begin
                        if (w_last_write) begin
                            r_state <= c_idle;
                        end
                    end
                    default: r_state <= c_idle;
                endcase
            end
        end
    end

    slog_line_buf #(
        .DEPTH (SPR_W)
    ) u_buf (
        .Clk   (Clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (rom.rom_data),
        .raddr (w_col),
        .rdata (w_rdata)
    );

    // Column within the log; 10-bit wrap clips logs hanging off the left edge
    assign w_c   = DrawX - r_logx;
    assign w_hit = r_row_hit && (w_c < 10'(SPR_W));
    assign w_col = r_dir ? (6'(SPR_W - 1) - w_c[5:0]) : w_c[5:0];

    // Registered pixel output, one cycle behind DrawX
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pixel_idx   <= c_pal_transparent;
            r_pixel_valid <= 1'b0;
        end else begin
            r_pixel_idx   <= w_hit ? w_rdata : c_pal_transparent;
            r_pixel_valid <= w_hit && (w_rdata != c_pal_transparent);
        end
    end

    assign pixel_idx   = r_pixel_idx;
    assign pixel_valid = r_pixel_valid;
    assign busy        = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_slog_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slog_line_fetcher
//  Description : Directed self-checking bench for slog_line_fetcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slog_line_fetcher;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       line_start;
    logic [9:0] LogX;
    logic [9:0] LogY;
    logic       dir;
    logic [7:0] pixel_idx;
    logic       pixel_valid;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    slog_line_fetcher_if rom_if ();

    slog_line_fetcher dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .line_start  (line_start),
        .LogX        (LogX),
        .LogY        (LogY),
        .dir         (dir),
        .rom         (rom_if),
        .pixel_idx   (pixel_idx),
        .pixel_valid (pixel_valid),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM model: edge columns transparent, otherwise 3*dx + 2*dy + 7
    function automatic logic [7:0] rom_fn(input int dx, input int dy);
        if (dx == 0 || dx == 47) return 8'd0;
        return 8'(3 * dx + 2 * dy + 7);
    endfunction

    // One-cycle registered ROM
    always @(posedge Clk) rom_if.rom_data <= rom_fn(int'(rom_if.rom_DX), int'(rom_if.rom_DY));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic px(input logic [9:0] x);
        DrawX = x;
        tick();
    endtask

    // Start a hit line and check issued addresses and busy length
    task automatic fetch(input logic [9:0] dy, input logic [9:0] lx, input logic [9:0] ly,
                         input logic d, input int row);
        int errs = 0;
        int n;
        DrawY = dy; LogX = lx; LogY = ly; dir = d;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (rom_if.rom_DX !== 6'(i) || rom_if.rom_DY !== 6'(row) || busy !== 1'b1) errs++;
            tick();
        end
        chk("fetch_addr", errs, 0);
        n = 48;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("busy_len", n, 49);
    endtask

    // Walk the whole log span and compare against the ROM model
    task automatic sweep(input logic [9:0] lx, input int row, input logic d);
        int errs = 0;
        logic [7:0] e;
        for (int c = 0; c < 48; c++) begin
            px(lx + 10'(c));
            e = rom_fn(d ? 47 - c : c, row);
            if (pixel_idx !== e || pixel_valid !== (e != 8'd0)) errs++;
        end
        chk("sweep", errs, 0);
        px(lx - 10'd1);
        chk("left_outside", {pixel_valid, pixel_idx}, 0);
        px(lx + 10'd48);
        chk("right_outside", {pixel_valid, pixel_idx}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int errs;
        Reset = 1'b1; DrawX = '0; DrawY = '0; line_start = 1'b0;
        LogX = '0; LogY = '0; dir = 1'b0;
        repeat (3) tick();
        chk("rst_dx", rom_if.rom_DX, 0);
        chk("rst_dy", rom_if.rom_DY, 0);
        chk("rst_idx", pixel_idx, 0);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_busy", busy, 0);
        Reset = 1'b0;
        tick();

        // Normal row 2
        fetch(10'd201, 10'd100, 10'd200, 1'b0, 2);
        DrawY = 10'd202;
        px(10'd105);
        chk("n_idx105", pixel_idx, 26);
        chk("n_val105", pixel_valid, 1);
        px(10'd100);
        chk("n_idx100", pixel_idx, 0);
        chk("n_val100", pixel_valid, 0);
        sweep(10'd100, 2, 1'b0);

        // Reset 20 cycles into a fetch
        px(10'd105);
        chk("pre_rst_idx", pixel_idx, 26);
        DrawY = 10'd204; LogY = 10'd200; LogX = 10'd100; dir = 1'b1;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (19) tick();
        chk("mid_dy", rom_if.rom_DY, 5);
        Reset = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_dx", rom_if.rom_DX, 0);
        chk("mrst_dy", rom_if.rom_DY, 0);
        chk("mrst_idx", pixel_idx, 0);
        chk("mrst_valid", pixel_valid, 0);
        Reset = 1'b0;
        errs = 0;
        for (int x = 100; x < 148; x++) begin
            px(10'(x));
            if (pixel_valid !== 1'b0) errs++;
        end
        chk("mrst_line_valid", errs, 0);

        // Mirrored row 5
        fetch(10'd204, 10'd100, 10'd200, 1'b1, 5);
        px(10'd100);
        chk("m_idx100", pixel_idx, 0);
        chk("m_val100", pixel_valid, 0);
        px(10'd144);
        chk("m_idx144", pixel_idx, 26);
        chk("m_val144", pixel_valid, 1);
        sweep(10'd100, 5, 1'b1);

        // No-hit line: no fetch, address held, nothing displayed
        DrawY = 10'd300;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("nh_busy", busy, 0);
        tick();
        chk("nh_busy2", busy, 0);
        chk("nh_dx", rom_if.rom_DX, 47);
        chk("nh_dy", rom_if.rom_DY, 5);
        errs = 0;
        for (int x = 0; x < 640; x++) begin
            px(10'(x));
            if (pixel_valid !== 1'b0) errs++;
        end
        chk("nh_line_valid", errs, 0);

        // Frame wrap: DrawY=524 fetches row 0 of a log at LogY=0
        fetch(10'd524, 10'd200, 10'd0, 1'b0, 0);
        px(10'd205);
        chk("wrap_idx", pixel_idx, 22);

        // Left clip: LogX=1020
        fetch(10'd524, 10'd1020, 10'd0, 1'b0, 0);
        px(10'd2);
        chk("clip_idx2", pixel_idx, 25);
        chk("clip_val2", pixel_valid, 1);
        px(10'd1019);
        chk("clip_1019", {pixel_valid, pixel_idx}, 0);
        px(10'd1021);
        chk("clip_idx1021", pixel_idx, 10);

        // Abort at t+10 with a new LogY; buffer must hold only the new row
        DrawY = 10'd201; LogX = 10'd100; LogY = 10'd200; dir = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (9) tick();
        chk("abort_busy", busy, 1);
        fetch(10'd201, 10'd100, 10'd190, 1'b0, 12);
        sweep(10'd100, 12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slog_line_fetcher.md
# slog_line_fetcher

Scanline renderer for the 48x24 log sprite ROM: it is the reader side of the sprite ROM's DX/DY → data interface. During horizontal blanking it fetches the sprite row needed for the next scanline into a 48-entry line buffer. During active video it outputs the palette index for the current pixel, with optional horizontal mirroring. It sits between the VGA timing/position logic and the colour mapper, one instance per on-screen log.

## Interface
Parameters:
- SPR_W, 48, sprite width in pixels
- SPR_H, 24, sprite height in rows
- V_TOTAL, 525, total lines per frame; used to wrap next-line computation
- ROM_LAT, 1, cycles from rom_DX/rom_DY change to valid rom_data

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current scanline
- line_start  in  1  one-cycle pulse at start of horizontal blank
- LogX  in  10  left edge of log, sampled at line_start
- LogY  in  10  top row of log, sampled at line_start
- dir  in  1  0 = normal, 1 = mirrored horizontally; sampled at line_start
- rom_DX  out  6  sprite column address to ROM
- rom_DY  out  6  sprite row address to ROM
- rom_data  in  8  palette index from ROM
- pixel_idx  out  8  palette index for current pixel, 0 when not covered
- pixel_valid  out  1  1 when pixel_idx is opaque (nonzero) and inside the log
- busy  out  1  1 while FETCH is in progress

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE, line_start=1:
  - ny = (DrawY+1 == V_TOTAL) ? 0 : DrawY+1; r = ny − LogY as 10-bit unsigned.
  - If r < SPR_H: latch row=r[5:0], LogX, dir; clear cnt; row_hit_next=1; go FETCH.
  - Else: row_hit_next=0; stay IDLE.
- FETCH: drive rom_DY=row, rom_DX=cnt. Increment cnt every cycle. After cnt = SPR_W−1 is issued, go DRAIN.
- ROM returns are captured ROM_LAT cycles after issue into buf[issued cnt]; a delayed-address pipeline of depth ROM_LAT tracks write enable and address.
- DRAIN: wait ROM_LAT cycles for the last write, then go IDLE.
- row_hit (the hit flag used for display) is loaded from row_hit_next on the same cycle as the last buffer write. On lines with no hit it is loaded at line_start.
- line_start during FETCH/DRAIN: abort the current fetch (in-flight writes dropped) and re-evaluate as in IDLE. Not expected in normal timing.
- Display path, always active:
  - c = DrawX − LogX_lat (10-bit).
  - hit = row_hit and c < SPR_W.
  - col = dir_lat ? SPR_W−1−c : c.
  - pixel_idx = hit ? buf[col] : 0; pixel_valid = hit and pixel_idx≠0.
- Logs partially off the left edge: LogX is treated as 10-bit with wrap. c wraps, so columns are correctly clipped. No signed arithmetic.
- rom_DX/rom_DY hold their last value outside FETCH.

## Timing
- Reset values: state=IDLE, cnt=0, row_hit=0, rom_DX=0, rom_DY=0, pixel_idx=0, pixel_valid=0, busy=0. Buffer contents are undefined after reset, but are unreachable because row_hit=0.
- Reset asserted mid-FETCH: next cycle is IDLE with all outputs at reset values.
- Fetch length: line_start at cycle t → addresses issued t+1..t+48. The last write is at t+48+ROM_LAT, and busy falls in the same cycle. This must fit in horizontal blank (160 cycles).
- Display latency: pixel_idx/pixel_valid are registered, one cycle after DrawX. The colour mapper compensates.
- busy=1 exactly in FETCH and DRAIN.

## Structure
- Package slog_pkg holds:
  - SPR_W/SPR_H defaults
  - the state enum typedef (IDLE, FETCH, DRAIN)
  - the palette index typedef (logic [7:0])
  - the transparent index constant (0)
- Sub-module slog_line_buf: 48x8 buffer with one synchronous write port and one asynchronous read port. It keeps the buffer separate from the FSM.
- The ROM itself stays external and is connected via rom_DX/rom_DY/rom_data.

## Test plan
- Reset mid-FETCH (cycle t+20): all outputs 0 next cycle, busy=0, pixel_valid=0 on the following active line.
- Log at LogX=100, LogY=200, dir=0, line_start with DrawY=201 (row 2):
  - 48 ROM reads with rom_DY=2; busy high for 48+ROM_LAT cycles.
  - On line 202, DrawX=105 → pixel_idx=26 one cycle later, pixel_valid=1.
  - DrawX=100 → pixel_idx=0, pixel_valid=0.
- Same log with dir=1 on row 5: DrawX=100 → buf[47] = 0 (transparent); DrawX=144 → buf[3] = 26.
- No-hit line, DrawY=300: no FETCH, rom address unchanged, pixel_valid=0 across the whole line.
- Wrap: LogY=0, DrawY=524 at line_start → ny=0, row 0 fetched.
- Left clip: LogX=1020 → pixel at DrawX=2 shows col 6.
- line_start pulsed at t+10 of a FETCH with a new LogY: fetch restarts. The final buffer must match the new row exactly, with no stale entries.
